// File: rtl/ddr_des_align.sv
// ddr_des_align: DDR sample deserializer with bit-slip word alignment on a training pattern.
// Optional lock-loss detection is compiled in with DDR_DES_ALIGN_LOSS_DET_EN.
module ddr_des_align #(
  parameter int WORD_WIDTH = 10,
  parameter int IN_WIDTH = 2,
  parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN = 10'b0101111100,
  parameter int LOCK_COUNT = 4,
  parameter int SYNC_TIMEOUT = 256
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [IN_WIDTH-1:0]           IN,
  input  logic                          RESYNC,
  output logic [WORD_WIDTH-1:0]         DATA,
  output logic                          DATA_VALID,
  output logic                          LOCKED,
  output logic [$clog2(WORD_WIDTH)-1:0] OFFSET,
  output logic [7:0]                    LOSS_CNT
);
  localparam int HW = 2 * WORD_WIDTH;
  localparam int RATIO = WORD_WIDTH / IN_WIDTH;
  localparam int PW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int OW = $clog2(WORD_WIDTH);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  if (WORD_WIDTH % IN_WIDTH != 0 || WORD_WIDTH < 2 || LOCK_COUNT < 1 || SYNC_TIMEOUT < 1) begin : g_param_err
    $error("ddr_des_align: illegal parameter combination");
  end
  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_e;
  state_e state_q, state_d;
  logic [HW-1:0] hist_q, hist_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [WORD_WIDTH-1:0] data_q, data_d, word;
  logic dv_q, dv_d, locked_q, locked_d, bnd, match;
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
  localparam int GW = $clog2(SYNC_TIMEOUT + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] loss_q, loss_d;
  logic timeout;
  assign LOSS_CNT = loss_q;
`else
  assign LOSS_CNT = 8'd0;
`endif
  assign bnd = ph_q == PW'(RATIO - 1);
  assign word = hist_q[offset_q +: WORD_WIDTH];
  assign match = bnd && word == SYNC_PATTERN;
  always_comb begin
    hist_d = {hist_q[HW-IN_WIDTH-1:0], IN};
    ph_d = bnd ? '0 : ph_q + 1'b1;
    state_d = state_q;
    cnt_d = cnt_q;
    offset_d = offset_q;
    data_d = data_q;
    dv_d = 1'b0;
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
    gap_d = gap_q;
    loss_d = loss_q;
    timeout = gap_q >= GW'(SYNC_TIMEOUT);
`endif
    if (RESYNC) begin
      state_d = S_SEARCH;
      cnt_d = '0;
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
      gap_d = '0;
`endif
    end else if (bnd && state_q == S_LOCKED) begin
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
      // the word that would exceed the sync gap is discarded and drops lock
      gap_d = match || timeout ? '0 : gap_q + 1'b1;
      state_d = !match && timeout ? S_SEARCH : S_LOCKED;
      loss_d = !match && timeout ? loss_q + 8'(loss_q != 8'hFF) : loss_q;
      dv_d = !match && !timeout;
`else
      dv_d = !match;
`endif
      data_d = dv_d ? word : data_q;
    end else if (match) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q + 1'b1 == CW'(LOCK_COUNT) ? S_LOCKED : S_VERIFY;
    end else if (bnd) begin
      offset_d = offset_q == OW'(WORD_WIDTH - 1) ? '0 : offset_q + 1'b1;
      cnt_d = '0;
      state_d = S_SEARCH;
    end
    locked_d = state_d == S_LOCKED;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_SEARCH;
      hist_q <= '0;
      ph_q <= '0;
      cnt_q <= '0;
      offset_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      locked_q <= 1'b0;
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
      gap_q <= '0;
      loss_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      offset_q <= offset_d;
      data_q <= data_d;
      dv_q <= dv_d;
      locked_q <= locked_d;
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
      gap_q <= gap_d;
      loss_q <= loss_d;
`endif
    end
  end
  assign DATA = data_q;
  assign DATA_VALID = dv_q;
  assign LOCKED = locked_q;
  assign OFFSET = offset_q;
endmodule

// File: tb/tb_ddr_des_align.sv
// tb_ddr_des_align: directed + randomized bench for ddr_des_align against a bit-stream reference model.
module tb_ddr_des_align;
  localparam int W = 10, IW = 2, RATIO = W / IW, LC = 4, TO = 8;
  localparam logic [W-1:0] SYNC = 10'b0101111100;
`ifdef DDR_DES_ALIGN_LOSS_DET_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst, rsync;
  logic [IW-1:0] din;
  logic [W-1:0] data;
  logic dv, locked;
  logic [3:0] offset;
  logic [7:0] loss_cnt;
  int tests = 0, fails = 0;
  bit tx[$];
  bit bits[$];
  int m_ph, m_off, m_st, m_cnt, m_gap, m_loss, edges;
  logic [W-1:0] m_data;
  bit m_dv;

  ddr_des_align #(.WORD_WIDTH(W), .IN_WIDTH(IW), .SYNC_PATTERN(SYNC), .LOCK_COUNT(LC), .SYNC_TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .IN(din), .RESYNC(rsync), .DATA(data), .DATA_VALID(dv),
    .LOCKED(locked), .OFFSET(offset), .LOSS_CNT(loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // word seen at slip offset off: W bits ending off bits before the newest sample, oldest bit first
  function automatic logic [W-1:0] cand(input int off);
    logic [W-1:0] w;
    int base;
    base = bits.size() - off - W;
    for (int i = 0; i < W; i++) w[W-1-i] = (base + i >= 0) ? bits[base+i] : 1'b0;
    return w;
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_off = 0; m_st = 0; m_cnt = 0; m_gap = 0; m_loss = 0; edges = 0;
    m_data = '0; m_dv = 1'b0;
    bits.delete();
  endfunction

  task automatic model_edge(input logic [IW-1:0] s, input bit rs);
    bit bnd, mt;
    logic [W-1:0] w;
    bnd = m_ph == RATIO - 1;
    w = cand(m_off);
    mt = bnd && w == SYNC;
    m_dv = 1'b0;
    if (rs) begin
      m_st = 0; m_cnt = 0; m_gap = 0;
    end else if (bnd) begin
      if (m_st == 2) begin
        if (mt) m_gap = 0;
        else if (LOSS_EN && m_gap + 1 > TO) begin
          m_st = 0; m_gap = 0;
          if (m_loss < 255) m_loss++;
        end else begin
          m_data = w; m_dv = 1'b1; m_gap++;
        end
      end else if (mt) begin
        m_cnt++;
        m_st = m_cnt >= LC ? 2 : 1;
      end else begin
        m_off = (m_off + 1) % W; m_st = 0; m_cnt = 0;
      end
    end
    m_ph = (m_ph + 1) % RATIO;
    for (int i = IW - 1; i >= 0; i--) bits.push_back(s[i]);
    edges++;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) tx.push_back(w[i]);
  endtask

  task automatic cycle(input bit rs, input bit flip);
    logic [IW-1:0] s;
    if (tx.size() < IW) push_word(SYNC);
    for (int i = IW - 1; i >= 0; i--) s[i] = tx.pop_front();
    if (flip) s = ~s;
    din = s;
    rsync = rs;
    @(posedge clk);
    model_edge(s, rs);
    #1;
    chk("data", data, m_data);
    chk("data_valid", dv, m_dv);
    chk("locked", locked, m_st == 2);
    chk("offset", offset, m_off);
    chk("loss_cnt", loss_cnt, m_loss);
  endtask

  task automatic start_stream();
    tx.delete();
    for (int i = 4; i >= 0; i--) tx.push_back(SYNC[i]);
  endtask

  task automatic acquire(input string tag);
    int le, slips, prev;
    le = -1; slips = 0; prev = 0;
    for (int i = 0; i < 100 && le < 0; i++) begin
      cycle(1'b0, 1'b0);
      if (offset !== prev[3:0]) slips++;
      prev = offset;
      if (locked === 1'b1) le = edges;
    end
    chk({tag, "_lock_edge"}, le, 35);
    chk({tag, "_slips"}, slips, 3);
    chk({tag, "_offset"}, offset, 3);
  endtask

  initial begin
    int nb, np, t[$];
    bit hit, bnd, unl;
    logic [W-1:0] w, v[$];
    rst = 1'b1; rsync = 1'b0; din = '0;
    model_reset();
    start_stream();
    #12;
    chk("rst_data", data, 0);
    chk("rst_dv", dv, 0);
    chk("rst_locked", locked, 0);
    chk("rst_offset", offset, 0);
    chk("rst_loss", loss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    acquire("acq");

    push_word(10'h155); push_word(10'h2AA); push_word(SYNC); push_word(10'h001);
    for (int i = 0; i < 60 && v.size() < 3; i++) begin
      cycle(1'b0, 1'b0);
      if (dv === 1'b1) begin v.push_back(data); t.push_back(edges); end
    end
    chk("dv_count", v.size(), 3);
    chk("dv0", v[0], 10'h155);
    chk("dv1", v[1], 10'h2AA);
    chk("dv2", v[2], 10'h001);
    chk("dv_gap01", t[1] - t[0], 5);
    chk("dv_gap12", t[2] - t[1], 10);
    chk("data_offset", offset, 3);

    for (int j = 0; j < 24; j++) begin
      if (j % 4 == 3) w = SYNC;
      else begin
        w = W'($urandom);
        while (w == SYNC) w = W'($urandom);
      end
      push_word(w);
    end
    for (int i = 0; i < 24 * RATIO + 10; i++) cycle(1'b0, 1'b0);

    push_word(10'h0F0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      hit = m_ph == RATIO - 1 && m_st == 2 && cand(m_off) == 10'h0F0;
      cycle(hit, 1'b0);
    end
    chk("resync_hit", hit, 1);
    chk("resync_dv", dv, 0);
    chk("resync_locked", locked, 0);
    chk("resync_offset", offset, 3);
    nb = 0;
    for (int i = 0; i < 60 && locked !== 1'b1; i++) begin
      bnd = m_ph == RATIO - 1;
      cycle(1'b0, 1'b0);
      if (bnd) nb++;
    end
    chk("relock_boundaries", nb, 4);

    for (int i = 0; i < RATIO && m_ph != 0; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("resync2_locked", locked, 0);
    for (int i = 0; i < 40 && !(m_st == 1 && m_cnt == 2); i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    nb = 0;
    for (int i = 0; i < 120 && locked !== 1'b1; i++) begin
      bnd = m_ph == RATIO - 1;
      cycle(1'b0, 1'b0);
      if (bnd) nb++;
      if (bnd && nb == 1) chk("corrupt_slip", offset, 4);
    end
    chk("corrupt_relock_boundaries", nb, 14);

    for (int j = 0; j < 9; j++) begin
      w = W'($urandom);
      while (w == SYNC) w = W'($urandom);
      push_word(w);
    end
    np = 0; unl = 1'b0;
    for (int i = 0; i < 90; i++) begin
      cycle(1'b0, 1'b0);
      if (dv === 1'b1) np++;
      if (locked === 1'b0) unl = 1'b1;
    end
    chk("loss_pulses", np, LOSS_EN ? TO : 9);
    chk("loss_unlock", unl, LOSS_EN);
    chk("loss_count", loss_cnt, LOSS_EN);
    chk("loss_relocked", locked, 1);
    chk("loss_offset", offset, 3);

    cycle(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", data, 0);
    chk("arst_dv", dv, 0);
    chk("arst_locked", locked, 0);
    chk("arst_offset", offset, 0);
    chk("arst_loss", loss_cnt, 0);
    model_reset();
    start_stream();
    #2 rst = 1'b0;
    acquire("reacq");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
